cac_fns_encoder_seq: RTL and testbench



---
 rtl/cac_fns_encoder_seq.sv | 150 +++++++++++++++
 tb/tb_cac_fns_encoder_seq.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cac_fns_encoder_seq.sv
// rtl/cac_fns_encoder_seq.sv - sequential Fibonacci-numeral-system CAC encoder
// Resolves one code bit per clock, MSB first, with ready/valid on both sides.
module cac_fns_encoder_seq #(
  parameter int CODE_W = 6,
  parameter int DATA_W = 5
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] datain,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] codeout,
  output logic              range_err,
  output logic              busy
);

  localparam int CNT_W = $clog2(CODE_W);

  // Fibonacci weight W[k] with W[0] = W[1] = 1
  function automatic longint fib_w(input int k);
    longint a, b, t;
    a = 1;
    b = 1;
    for (int i = 2; i <= k; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return b;
  endfunction

  localparam longint MAXV_L = fib_w(CODE_W + 1) - 1;
  localparam logic [DATA_W-1:0] MAXV = DATA_W'(MAXV_L);

  generate
    if (CODE_W < 3 || CODE_W > 24) begin : g_bad_code_w
      $error("cac_fns_encoder_seq: CODE_W must be within 3..24");
    end
    if ((64'd1 << DATA_W) < 64'(fib_w(CODE_W + 1))) begin : g_bad_data_w
      $error("cac_fns_encoder_seq: DATA_W too narrow for the code range");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t              state, state_nx;
  logic [DATA_W-1:0]   r;
  logic                err_q;
  logic [CNT_W-1:0]    k;
  logic [CODE_W-1:0]   code_sr;
  logic [CODE_W-1:0]   code_set;
  logic [DATA_W-1:0]   w_k;
  logic [DATA_W-1:0]   t_k;
  logic                bit_k;
  logic                over;

  assign over = (datain > MAXV);

  // Weight and greedy threshold for the bit under evaluation; the threshold
  // alternates between W[k] and W[k+1] with the distance from the MSB.
  always_comb begin
    w_k = '0;
    t_k = '0;
    for (int i = 0; i < CODE_W; i++) begin
      if (k == CNT_W'(i)) begin
        w_k = DATA_W'(fib_w(i));
        t_k = ((CODE_W - 1 - i) % 2 == 0) ? DATA_W'(fib_w(i)) : DATA_W'(fib_w(i + 1));
      end
    end
  end

  assign bit_k = (r >= t_k);

  always_comb begin
    code_set    = code_sr;
    code_set[k] = bit_k;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = S_CALC;
      end
      S_CALC: begin
        busy = 1'b1;
        if (k == '0) state_nx = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Results are published only on the edge that enters DONE, so they hold
  // through any downstream stall and across the following IDLE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r         <= '0;
      err_q     <= 1'b0;
      k         <= '0;
      code_sr   <= '0;
      codeout   <= '0;
      range_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            r       <= over ? MAXV : datain;
            err_q   <= over;
            k       <= CNT_W'(CODE_W - 1);
            code_sr <= '0;
          end
        end
        S_CALC: begin
          code_sr <= code_set;
          if (bit_k) r <= r - w_k;
          if (k == '0) begin
            codeout   <= code_set;
            range_err <= err_q;
          end else begin
            k <= k - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cac_fns_encoder_seq.sv
// tb/tb_cac_fns_encoder_seq.sv - scoreboard bench for cac_fns_encoder_seq
// Drives a CODE_W=6 and a CODE_W=9 instance and checks against a greedy model.
module tb_cac_fns_encoder_seq;

  logic       clock;
  logic       reset_n;
  logic       iv0, ir0, ov0, or0, err0, busy0;
  logic [4:0] din0;
  logic [5:0] code0;
  logic       iv1, ir1, ov1, or1, err1, busy1;
  logic [6:0] din1;
  logic [8:0] code1;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic [8:0] code;
    logic       err;
    int         v;
    int         acc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  logic pv0, pv1;
  int   owner6[64];

  cac_fns_encoder_seq #(.CODE_W(6), .DATA_W(5)) u_dut6 (
    .clock(clock), .reset_n(reset_n), .in_valid(iv0), .in_ready(ir0), .datain(din0),
    .out_valid(ov0), .out_ready(or0), .codeout(code0), .range_err(err0), .busy(busy0)
  );

  cac_fns_encoder_seq #(.CODE_W(9), .DATA_W(7)) u_dut9 (
    .clock(clock), .reset_n(reset_n), .in_valid(iv1), .in_ready(ir1), .datain(din1),
    .out_valid(ov1), .out_ready(or1), .codeout(code1), .range_err(err1), .busy(busy1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int wt(input int k);
    int a = 1, b = 1, t;
    for (int i = 2; i <= k; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return b;
  endfunction

  function automatic int sat(input int cw, input int v);
    return (v > wt(cw + 1) - 1) ? wt(cw + 1) - 1 : v;
  endfunction

  function automatic int wsum(input int cw, input logic [8:0] c);
    int s = 0;
    for (int i = 0; i < cw; i++) if (c[i]) s += wt(i);
    return s;
  endfunction

  function automatic void model(input int cw, input int v, output logic [8:0] c, output logic e);
    int r, t;
    c = '0;
    e = (v > wt(cw + 1) - 1);
    r = sat(cw, v);
    for (int kk = cw - 1; kk >= 0; kk--) begin
      t = ((cw - 1 - kk) % 2 == 0) ? wt(kk) : wt(kk + 1);
      if (r >= t) begin
        c[kk] = 1'b1;
        r -= wt(kk);
      end
    end
  endfunction

  // use_lit selects a hand-derived expectation instead of the model
  task automatic send(input int inst, input int v, input bit use_lit,
                      input logic [8:0] lit_code, input logic lit_err);
    exp_t x;
    int   g;
    model(inst ? 9 : 6, v, x.code, x.err);
    if (use_lit) begin
      x.code = lit_code;
      x.err  = lit_err;
    end
    x.v = v;
    @(posedge clock); #1;
    if (inst == 0) begin iv0 = 1'b1; din0 = 5'(v); end
    else           begin iv1 = 1'b1; din1 = 7'(v); end
    g = 0;
    do begin
      @(negedge clock);
      g++;
    end while (!(inst ? ir1 : ir0) && g < 300);
    if (g >= 300) begin
      check("send_timeout", 0, 1);
    end else begin
      x.acc = cyc + 1;
      if (inst == 0) q0.push_back(x);
      else           q1.push_back(x);
    end
    @(posedge clock); #1;
    if (inst == 0) iv0 = 1'b0;
    else           iv1 = 1'b0;
  endtask

  task automatic drain(input int inst);
    int g = 0;
    while ((inst ? q1.size() : q0.size()) != 0 && g < 500) begin
      @(negedge clock);
      g++;
    end
    if (g >= 500) check("drain_timeout", 0, 1);
  endtask

  always @(negedge clock) begin
    if (!reset_n) begin
      pv0 = 1'b0;
    end else begin
      if (ov0 && !pv0) begin
        if (q0.size() == 0) check("unexpected_out6", 1, 0);
        else                check("latency6", cyc - q0[0].acc, 6);
      end
      if (ov0 && or0 && q0.size() > 0) begin
        e0 = q0.pop_front();
        check("code6", code0, e0.code[5:0]);
        check("err6", err0, e0.err);
        check("wsum6", wsum(6, {3'b0, code0}), sat(6, e0.v));
        if (!e0.err) begin
          check("uniq6", (owner6[code0] == -1 || owner6[code0] == e0.v), 1);
          owner6[code0] = e0.v;
        end
      end
      pv0 = ov0;
    end
  end

  always @(negedge clock) begin
    if (!reset_n) begin
      pv1 = 1'b0;
    end else begin
      if (ov1 && !pv1) begin
        if (q1.size() == 0) check("unexpected_out9", 1, 0);
        else                check("latency9", cyc - q1[0].acc, 9);
      end
      if (ov1 && or1 && q1.size() > 0) begin
        e1 = q1.pop_front();
        check("code9", code1, e1.code);
        check("err9", err1, e1.err);
        check("wsum9", wsum(9, code1), sat(9, e1.v));
      end
      pv1 = ov1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] held;
    int g;
    for (int i = 0; i < 64; i++) owner6[i] = -1;
    reset_n = 1'b0;
    iv0 = 1'b0; or0 = 1'b1; din0 = '0;
    iv1 = 1'b0; or1 = 1'b1; din1 = '0;
    repeat (3) @(negedge clock);
    check("rst_out_valid", ov0, 0);
    check("rst_codeout", code0, 0);
    check("rst_range_err", err0, 0);
    check("rst_busy", busy0, 0);
    check("rst_codeout9", code1, 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(negedge clock);
    check("rst_in_ready", ir0, 1);
    check("rst_in_ready9", ir1, 1);

    // hand-derived codewords from the greedy rule
    send(0, 20, 1, 9'h03F, 1'b0);
    send(0, 0,  1, 9'h000, 1'b0);
    send(0, 7,  1, 9'h00F, 1'b0);
    send(0, 8,  1, 9'h020, 1'b0);
    send(0, 10, 1, 9'h023, 1'b0);
    send(0, 13, 1, 9'h02B, 1'b0);
    drain(0);
    for (int v = 0; v <= 20; v++) send(0, v, 0, '0, 1'b0);
    send(0, 31, 1, 9'h03F, 1'b1);
    send(0, 5,  1, 9'h00B, 1'b0);
    drain(0);

    // downstream stall in DONE with ignored input pulses
    @(posedge clock); #1;
    or0 = 1'b0;
    send(0, 13, 0, '0, 1'b0);
    g = 0;
    while (!ov0 && g < 50) begin
      @(negedge clock);
      g++;
    end
    check("bp_reach_done", ov0, 1);
    held = code0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      iv0  = (i % 2 == 0);
      din0 = 5'd3;
      @(negedge clock);
      check("bp_code_hold", code0, held);
      check("bp_in_ready", ir0, 0);
      check("bp_out_valid", ov0, 1);
    end
    @(posedge clock); #1;
    iv0 = 1'b0;
    or0 = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("bp_release_ready", ir0, 1);
    check("bp_release_valid", ov0, 0);
    repeat (10) @(negedge clock);
    check("bp_no_capture", ov0, 0);

    // asynchronous reset while bit 3 is being resolved
    @(posedge clock); #1;
    iv0  = 1'b1;
    din0 = 5'd9;
    @(negedge clock);
    @(posedge clock); #1;
    iv0 = 1'b0;
    @(posedge clock);
    @(posedge clock); #3;
    check("pre_rst_busy", busy0, 1);
    reset_n = 1'b0;
    #1;
    check("arst_codeout", code0, 0);
    check("arst_out_valid", ov0, 0);
    check("arst_busy", busy0, 0);
    check("arst_range_err", err0, 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(negedge clock);
    check("arst_in_ready", ir0, 1);
    send(0, 12, 0, '0, 1'b0);
    drain(0);

    for (int v = 0; v < 128; v++) send(1, v, 0, '0, 1'b0);
    drain(1);

    check("q6_empty", q0.size(), 0);
    check("q9_empty", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
